// File: rtl/sumador_arbitro_pkg.sv
// -----------------------------------------------------------------------------
// sumador_arbitro_pkg
// Shared constants for the round-robin sumador scheduler and its adder:
//   - FSM state encodings (IDLE -> LOAD -> CAPT -> IDLE)
//   - operand, result and sel widths of the shared sumador
// -----------------------------------------------------------------------------
package sumador_arbitro_pkg;

    localparam int OPW  = 8;   // one battery reading
    localparam int RESW = 9;   // adder result, carry in bit 8
    localparam int SELW = 2;   // sumador operation select

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;

endpackage

// File: rtl/sumador_arbitro_sumador.sv
// -----------------------------------------------------------------------------
// sumador_arbitro_sumador
// The shared combinational battery adder.
// Ports:
//   sel       in  2   operation select
//                     00: a + b
//                     01: a + b + 1
//                     10: a + a
//                     11: b + b
//   baterias  in  16  {a, b}: reading a in [15:8], reading b in [7:0]
//   sum       out 9   full-width result, never truncated
// -----------------------------------------------------------------------------
module sumador_arbitro_sumador
    import sumador_arbitro_pkg::*;
(
    input  logic [SELW-1:0]  sel,
    input  logic [2*OPW-1:0] baterias,
    output logic [RESW-1:0]  sum
);

    logic [RESW-1:0] a_ext;
    logic [RESW-1:0] b_ext;

    assign a_ext = {1'b0, baterias[2*OPW-1:OPW]};
    assign b_ext = {1'b0, baterias[OPW-1:0]};

    always_comb begin
        case (sel)
            2'b00:   sum = a_ext + b_ext;
            2'b01:   sum = a_ext + b_ext + RESW'(1);
            2'b10:   sum = a_ext + a_ext;
            default: sum = b_ext + b_ext;
        endcase
    end

endmodule

// File: rtl/sumador_arbitro.sv
// -----------------------------------------------------------------------------
// sumador_arbitro
// Round-robin scheduler sharing one sumador among NREQ requesters. A granted
// requester's operands are registered into the adder, the sum is captured two
// cycles later and returned tagged with the requester id.
// Ports:
//   clk        in   1        system clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   req        in   NREQ     request level per requester, held until granted
//   op_a       in   NREQ*8   operand A, slice i = [8*i+7:8*i]
//   op_b       in   NREQ*8   operand B, same slicing
//   op_sel     in   NREQ*2   sumador sel, slice i = [2*i+1:2*i]
//   grant      out  NREQ     one-hot pulse in the accepting cycle
//   res        out  9        captured adder result (holds between pulses)
//   res_id     out  IDW      owner of res (holds between pulses)
//   res_valid  out  1        single-cycle pulse qualifying res/res_id
//   busy       out  1        FSM not in IDLE
//
// Handshake: req is a level; the cycle grant[i] is high is the only cycle in
// which requester i's operands are sampled. The requester may drop req or
// change operands from the next cycle on. Results are fire-and-forget:
// res_valid is a one-cycle pulse with no back-pressure.
// -----------------------------------------------------------------------------
module sumador_arbitro
    import sumador_arbitro_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*OPW-1:0]  op_a,
    input  logic [NREQ*OPW-1:0]  op_b,
    input  logic [NREQ*SELW-1:0] op_sel,
    output logic [NREQ-1:0]      grant,
    output logic [RESW-1:0]      res,
    output logic [IDW-1:0]       res_id,
    output logic                 res_valid,
    output logic                 busy
);

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;       // last requester served
    logic [IDW-1:0]  id;        // requester currently in the adder
    logic [OPW-1:0]  reg_a;
    logic [OPW-1:0]  reg_b;
    logic [SELW-1:0] reg_sel;
    logic [RESW-1:0] sum;

    logic            found;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic            accept;
    logic [OPW-1:0]  win_a;
    logic [OPW-1:0]  win_b;
    logic [SELW-1:0] win_sel;

    // Rotating priority: scan ptr+1, ptr+2, ... wrapping modulo NREQ, so the
    // requester served last has the lowest priority next time.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Gated by rst_n so grant is low for the whole time reset is asserted,
    // even while requesters keep req high.
    assign accept = rst_n && (state == ST_IDLE) && found;

    always_comb begin
        grant   = '0;
        win_a   = '0;
        win_b   = '0;
        win_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                grant[i] = accept;
                win_a    = op_a[OPW*i +: OPW];
                win_b    = op_b[OPW*i +: OPW];
                win_sel  = op_sel[SELW*i +: SELW];
            end
        end
    end

    // The adder always sees the registered operands; LOAD is its settle cycle.
    sumador_arbitro_sumador u_sumador (
        .sel      (reg_sel),
        .baterias ({reg_a, reg_b}),
        .sum      (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= IDW'(NREQ - 1);
            id        <= '0;
            reg_a     <= '0;
            reg_b     <= '0;
            reg_sel   <= '0;
            res       <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        reg_a   <= win_a;
                        reg_b   <= win_b;
                        reg_sel <= win_sel;
                        id      <= win;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_CAPT;
                end
                ST_CAPT: begin
                    res       <= sum;
                    res_id    <= id;
                    res_valid <= 1'b1;
                    // Pointer moves only once the operation completes, so an
                    // aborted operation leaves fairness untouched.
                    ptr       <= id;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sumador_arbitro.sv
// -----------------------------------------------------------------------------
// tb_sumador_arbitro
// Directed scenarios followed by randomized traffic. A behavioural model
// (rotating priority by last-served id, a 3-cycle occupancy window and a
// result queue) predicts grant, busy, res_valid, res and res_id every cycle.
// -----------------------------------------------------------------------------
module tb_sumador_arbitro;
    import sumador_arbitro_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NREQ-1:0]      req;
    logic [NREQ*OPW-1:0]  op_a;
    logic [NREQ*OPW-1:0]  op_b;
    logic [NREQ*SELW-1:0] op_sel;
    logic [NREQ-1:0]      grant;
    logic [RESW-1:0]      res;
    logic [IDW-1:0]       res_id;
    logic                 res_valid;
    logic                 busy;

    sumador_arbitro #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .grant     (grant),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .busy      (busy)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [RESW-1:0] exp_q[$];
    logic [IDW-1:0]  exp_id_q[$];
    int              exp_due_q[$];

    int              cyc;
    int              last_id;
    int              grant_cyc;
    logic [NREQ-1:0] last_grant;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // What the sumador is supposed to compute, in plain arithmetic.
    function automatic logic [RESW-1:0] ref_sum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [1:0] s);
        int r;
        case (s)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) + int'(b) + 1;
            2'd2:    r = 2 * int'(a);
            default: r = 2 * int'(b);
        endcase
        return RESW'(r);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_id_q.delete();
        exp_due_q.delete();
        last_id    = NREQ - 1;
        grant_cyc  = -100;
        last_grant = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] s);
        op_a[8*i +: 8]   = a;
        op_b[8*i +: 8]   = b;
        op_sel[2*i +: 2] = s;
    endtask

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 5))
            0:       return 8'hFF;
            1:       return 8'h00;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // One clock cycle: called just after a negedge with inputs applied;
    // compares the current cycle against the model and returns at the next negedge.
    task automatic step();
        logic [NREQ-1:0] eg;
        int              w;
        logic            ev;
        logic            eb;
        #1;
        eg = '0;
        w  = -1;
        eb = (cyc - grant_cyc == 1) || (cyc - grant_cyc == 2);
        if (cyc - grant_cyc >= 3) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (last_id + k) % NREQ;
                if (w < 0 && req[j]) w = j;
            end
        end
        if (w >= 0) begin
            eg[w] = 1'b1;
            exp_q.push_back(ref_sum(op_a[8*w +: 8], op_b[8*w +: 8], op_sel[2*w +: 2]));
            exp_id_q.push_back(IDW'(w));
            exp_due_q.push_back(cyc + 3);
            grant_cyc = cyc;
            last_id   = w;
        end
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("busy", 32'(busy), 32'(eb));
        ev = (exp_due_q.size() > 0) && (exp_due_q[0] == cyc);
        check_eq("res_valid", 32'(res_valid), 32'(ev));
        if (ev) begin
            check_eq("res", 32'(res), 32'(exp_q[0]));
            check_eq("res_id", 32'(res_id), 32'(exp_id_q[0]));
            void'(exp_q.pop_front());
            void'(exp_id_q.pop_front());
            void'(exp_due_q.pop_front());
        end
        last_grant = eg;
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NREQ-1:0] one;
        one    = 4'b0001;
        cyc    = 0;
        rst_n  = 1'b0;
        req    = '0;
        op_a   = '0;
        op_b   = '0;
        op_sel = '0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_res", 32'(res), 0);
        check_eq("rst_res_id", 32'(res_id), 0);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin with all requesters held: 0,1,2,3,0 spaced 3 cycles.
        for (int i = 0; i < NREQ; i++) set_op(i, rnd8(), rnd8(), 2'b00);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            check_eq("rr_order", 32'(grant), 32'(one << (g % 4)));
            step(); step(); step();
        end
        req = '0;
        repeat (3) step();

        // Single request: 6 + 13.
        set_op(0, 8'd6, 8'd13, 2'b00);
        req = 4'b0001;
        step();
        req = '0;
        repeat (3) step();
        check_eq("single_res", 32'(res), 19);
        check_eq("single_id", 32'(res_id), 0);

        // Carry into bit 8, and the largest value without carry.
        set_op(2, 8'd255, 8'd255, 2'b00);
        req = 4'b0100;
        step();
        req = '0;
        repeat (3) step();
        check_eq("ovf_res", 32'(res), 510);
        check_eq("ovf_id", 32'(res_id), 2);
        set_op(2, 8'd255, 8'd0, 2'b00);
        req = 4'b0100;
        step();
        req = '0;
        repeat (3) step();
        check_eq("max_res", 32'(res), 255);

        // Operands change right after the grant cycle.
        set_op(1, 8'd80, 8'd65, 2'b00);
        req = 4'b0010;
        step();
        req = '0;
        op_a[15:8] = 8'd0;
        repeat (3) step();
        check_eq("hold_res", 32'(res), 145);
        check_eq("hold_id", 32'(res_id), 1);

        // req[3] pulsed while busy and dropped before IDLE: never served.
        set_op(0, 8'd1, 8'd2, 2'b00);
        req = 4'b0001;
        step();
        req = 4'b1000;
        step();
        req = '0;
        repeat (5) step();

        // Reset during LOAD: no result, pointer back so requester 0 wins.
        set_op(1, 8'd9, 8'd9, 2'b00);
        req = 4'b0010;
        step();
        req = 4'b0100;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_grant", 32'(grant), 0);
        check_eq("midrst_busy", 32'(busy), 0);
        check_eq("midrst_res", 32'(res), 0);
        check_eq("midrst_res_id", 32'(res_id), 0);
        check_eq("midrst_res_valid", 32'(res_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0101;
        #1;
        check_eq("midrst_next", 32'(grant), 32'(4'b0001));
        step();
        req = 4'b0100;
        repeat (4) step();
        req = '0;
        repeat (3) step();

        // Randomized traffic: requesters hold until granted, some cancel.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_grant[i]) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1)
                        set_op(i, rnd8(), rnd8(), 2'($urandom_range(0, 3)));
                end else if (!req[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        req[i] = 1'b1;
                        set_op(i, rnd8(), rnd8(), 2'($urandom_range(0, 3)));
                    end
                end else begin
                    if ($urandom_range(0, 19) == 0)
                        req[i] = 1'b0;
                    else if ($urandom_range(0, 9) == 0)
                        set_op(i, rnd8(), rnd8(), 2'($urandom_range(0, 3)));
                end
            end
            step();
        end
        req = '0;
        repeat (5) step();
        check_eq("drain", 32'(exp_due_q.size()), 0);

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
